adc_frame_aligner: RTL

Word-alignment stage directly downstream of the ADC deserializer. It takes the 8-bit words from the frame-clock lane and from one data lane, finds the bit offset at which the frame lane shows the ADC frame pattern, and confirms that lock over many words. It then outputs data-lane words re-aligned to that offset, with a lock indicator, to the sample-assembly and servo logic.

---
 rtl/adc_pkg.sv | 15 +
 rtl/window_select.sv | 16 +
 rtl/adc_frame_aligner.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame-alignment path: word width, default
// frame pattern and the alignment state encoding.
package adc_pkg;

    localparam int WORD_W = 8;

    localparam logic [WORD_W-1:0] FRAME_PATTERN_DEF = 8'hF0;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage

// File: rtl/window_select.sv
// Combinational 16-to-8 window extractor: returns hist_i[sel_i+7:sel_i].
`default_nettype none

module window_select
    import adc_pkg::*;
(
    input  logic [2*WORD_W-1:0] hist_i,
    input  logic [2:0]          sel_i,
    output logic [WORD_W-1:0]   win_o
);

    assign win_o = hist_i[{1'b0, sel_i} +: WORD_W];

endmodule

`default_nettype wire

// File: rtl/adc_frame_aligner.sv
// Finds the bit offset where the frame lane shows FRAME_PATTERN, confirms it
// over LOCK_COUNT words and emits data-lane words realigned to that offset.
`default_nettype none

module adc_frame_aligner
    import adc_pkg::*;
#(
    parameter logic [WORD_W-1:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
    parameter int                LOCK_COUNT    = 16,
    parameter int                UNLOCK_COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] frame_in,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              locked,
    output logic [2:0]        offset
);

    localparam logic [7:0] LOCK_CNT8   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_CNT8 = 8'(UNLOCK_COUNT);

    logic [WORD_W-1:0]   fr_prev_q;
    logic [WORD_W-1:0]   dt_prev_q;
    state_e              state_q;
    state_e              state_d;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic [2:0]          offset_q;
    logic [2:0]          offset_d;
    logic [WORD_W-1:0]   data_out_q;
    logic                data_valid_q;
    logic                locked_q;

    logic [2*WORD_W-1:0] fr_hist;
    logic [2*WORD_W-1:0] dt_hist;
    logic [WORD_W-1:0]   fr_win [WORD_W];
    logic [WORD_W-1:0]   match;
    logic [WORD_W-1:0]   dt_win;
    logic [2:0]          first_idx;
    logic                any_match;
    logic                m_cur;
    logic [7:0]          cnt_inc;

    assign fr_hist = {frame_in, fr_prev_q};
    assign dt_hist = {data_in, dt_prev_q};

    generate
        for (genvar k = 0; k < WORD_W; k++) begin : g_match
            window_select u_fr_win (
                .hist_i (fr_hist),
                .sel_i  (3'(k)),
                .win_o  (fr_win[k])
            );
            assign match[k] = (fr_win[k] == FRAME_PATTERN);
        end
    endgenerate

    window_select u_dt_win (
        .hist_i (dt_hist),
        .sel_i  (offset_q),
        .win_o  (dt_win)
    );

    // Scan from the top down so the lowest matching offset wins.
    always_comb begin
        first_idx = 3'd0;
        for (int k = WORD_W - 1; k >= 0; k--) begin
            if (match[k]) begin
                first_idx = 3'(k);
            end
        end
    end

    assign any_match = |match;
    assign m_cur     = match[offset_q];
    assign cnt_inc   = cnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        if (in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (any_match) begin
                        offset_d = first_idx;
                        cnt_d    = 8'd1;
                        state_d  = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (!m_cur) begin
                        state_d = ST_SEARCH;
                        cnt_d   = 8'd0;
                    end else if (cnt_inc == LOCK_CNT8) begin
                        state_d = ST_LOCKED;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_LOCKED: begin
                    if (m_cur) begin
                        cnt_d = 8'd0;
                    end else if (cnt_inc == UNLOCK_CNT8) begin
                        state_d = ST_SEARCH;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Data path uses offset_q, i.e. the alignment in force before this word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fr_prev_q    <= '0;
            dt_prev_q    <= '0;
            state_q      <= ST_SEARCH;
            cnt_q        <= 8'd0;
            offset_q     <= 3'd0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            offset_q     <= offset_d;
            locked_q     <= (state_d == ST_LOCKED);
            data_valid_q <= in_valid && (state_q == ST_LOCKED);
            if (in_valid) begin
                fr_prev_q  <= frame_in;
                dt_prev_q  <= data_in;
                data_out_q <= dt_win;
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;
    assign offset     = offset_q;

endmodule

`default_nettype wire
